// File: rtl/mario_motion_ctrl.sv
// Per-frame motion controller for the player sprite: turns keys and position into
// one-cycle step pulses for the x/y position counters and runs the jump arc FSM.
module mario_motion_ctrl #(
    parameter int JUMP_HEIGHT = 24,
    parameter int HANG_FRAMES = 3,
    parameter int GROUND_Y    = 115,
    parameter int X_MAX       = 155
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    input  logic [7:0] x_pos,
    input  logic [7:0] y_pos,
    output logic       x_enable,
    output logic       x_updown,
    output logic       y_enable,
    output logic       y_updown,
    output logic [1:0] state,
    output logic       airborne
);

    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, HANG = 2'd2, FALL = 2'd3} state_t;

    localparam logic [7:0] GY  = 8'(GROUND_Y);
    localparam logic [7:0] XM  = 8'(X_MAX);
    localparam logic [5:0] JH  = 6'(JUMP_HEIGHT);
    localparam logic [3:0] HF1 = 4'(HANG_FRAMES - 1);

    state_t     st;
    logic [5:0] rise_cnt;
    logic [3:0] hang_cnt;
    logic       jump_req;
    logic       jump_prev;

    assign state = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= GROUND;
            x_enable  <= 1'b0;
            x_updown  <= 1'b0;
            y_enable  <= 1'b0;
            y_updown  <= 1'b0;
            airborne  <= 1'b0;
            rise_cnt  <= '0;
            hang_cnt  <= '0;
            jump_req  <= 1'b0;
            jump_prev <= 1'b0;
        end else begin
            jump_prev <= key_jump;
            x_enable  <= 1'b0;
            y_enable  <= 1'b0;

            // Presses while airborne are dropped; consumption below overrides a same-cycle set.
            if (st == GROUND && key_jump && !jump_prev)
                jump_req <= 1'b1;

            if (frame_tick) begin
                if (key_right && !key_left && x_pos < XM) begin
                    x_enable <= 1'b1;
                    x_updown <= 1'b1;
                end else if (key_left && !key_right && x_pos != 8'd0) begin
                    x_enable <= 1'b1;
                    x_updown <= 1'b0;
                end

                case (st)
                    GROUND: begin
                        if (jump_req) begin
                            st       <= RISE;
                            airborne <= 1'b1;
                            jump_req <= 1'b0;
                            rise_cnt <= 6'd1;
                            y_enable <= 1'b1;
                            y_updown <= 1'b0;
                        end else if (y_pos < GY) begin
                            st       <= FALL;
                            airborne <= 1'b1;
                        end
                    end
                    RISE: begin
                        if (y_pos == 8'd0 || rise_cnt == JH) begin
                            st       <= HANG;
                            hang_cnt <= '0;
                        end else begin
                            y_enable <= 1'b1;
                            y_updown <= 1'b0;
                            if (rise_cnt != 6'h3f)
                                rise_cnt <= rise_cnt + 6'd1;
                        end
                    end
                    HANG: begin
                        if (hang_cnt == HF1)
                            st <= FALL;
                        else
                            hang_cnt <= hang_cnt + 4'd1;
                    end
                    FALL: begin
                        if (y_pos >= GY) begin
                            st       <= GROUND;
                            airborne <= 1'b0;
                        end else begin
                            y_enable <= 1'b1;
                            y_updown <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Directed bench for mario_motion_ctrl with x/y position counter models attached.
module tb_mario_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
    logic [7:0] x_pos, y_pos;
    logic       x_enable, x_updown, y_enable, y_updown, airborne;
    logic [1:0] state;

    logic       ld = 1'b0;
    logic [7:0] ldx = 8'd0, ldy = 8'd0;
    int         n_chk = 0, n_bad = 0, wide = 0;
    int         xp = 0, yup = 0, ydn = 0, airb_bad = 0;
    int         s_xp, s_yup, s_ydn;

    always #5 clk = ~clk;

    mario_motion_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
        .x_pos(x_pos), .y_pos(y_pos),
        .x_enable(x_enable), .x_updown(x_updown),
        .y_enable(y_enable), .y_updown(y_updown),
        .state(state), .airborne(airborne)
    );

    // Position counters driven by the step pulses
    always @(posedge clk) begin
        if (ld) begin
            x_pos <= ldx;
            y_pos <= ldy;
        end else begin
            if (x_enable) x_pos <= x_updown ? x_pos + 8'd1 : x_pos - 8'd1;
            if (y_enable) y_pos <= y_updown ? y_pos + 8'd1 : y_pos - 8'd1;
        end
    end

    always @(negedge clk) begin
        if (x_enable) xp++;
        if (y_enable && !y_updown) yup++;
        if (y_enable && y_updown) ydn++;
        if (!reset && airborne != (state != 2'd0)) airb_bad++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int xv, input int yv);
        @(negedge clk);
        ld = 1'b1; ldx = 8'(xv); ldy = 8'(yv);
        @(negedge clk);
        ld = 1'b0;
    endtask

    // One frame tick; pulses must be gone one cycle after they appear.
    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk) if (x_enable || y_enable) wide++;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic snap();
        s_xp = xp; s_yup = yup; s_ydn = ydn;
    endtask

    task automatic press_jump();
        @(negedge clk) key_jump = 1'b1;
        @(negedge clk);
        @(negedge clk) key_jump = 1'b0;
    endtask

    initial begin
        ld = 1'b1; ldx = 8'd20; ldy = 8'd115;
        repeat (3) @(negedge clk);
        ld = 1'b0;
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'({x_enable, x_updown, y_enable, y_updown, airborne}), 0);
        reset = 1'b0;

        // walk right 5 frames
        key_right = 1'b1; snap();
        ticks(5);
        chk("right_pulses", xp - s_xp, 5);
        chk("right_x", int'(x_pos), 25);
        chk("right_updown", int'(x_updown), 1);
        chk("right_no_y", yup + ydn - s_yup - s_ydn, 0);
        chk("right_state", int'(state), 0);

        // walk left one frame
        key_right = 1'b0; key_left = 1'b1;
        tick();
        chk("left_x", int'(x_pos), 24);
        chk("left_updown", int'(x_updown), 0);

        // limits and both keys
        load(155, 115); key_left = 1'b0; key_right = 1'b1; snap();
        ticks(3);
        chk("xmax_block", xp - s_xp, 0);
        load(0, 115); key_right = 1'b0; key_left = 1'b1; snap();
        ticks(3);
        chk("xmin_block", xp - s_xp, 0);
        load(50, 115); key_right = 1'b1; snap();
        ticks(3);
        chk("both_keys", xp - s_xp, 0);
        chk("both_x", int'(x_pos), 50);
        key_left = 1'b0; key_right = 1'b0;

        // full jump from ground
        press_jump(); snap();
        tick();
        chk("jump_rise", int'(state), 1);
        chk("jump_airborne", int'(airborne), 1);
        ticks(23);
        chk("rise_still", int'(state), 1);
        tick();
        chk("apex_state", int'(state), 2);
        chk("apex_y", int'(y_pos), 91);
        chk("apex_ups", yup - s_yup, 24);
        snap();
        ticks(2);
        chk("hang_state", int'(state), 2);
        tick();
        chk("hang_to_fall", int'(state), 3);
        chk("hang_no_y", yup + ydn - s_yup - s_ydn, 0);
        ticks(24);
        chk("fall_y", int'(y_pos), 115);
        chk("fall_downs", ydn - s_ydn, 24);
        chk("fall_state", int'(state), 3);
        tick();
        chk("land_state", int'(state), 0);
        chk("land_airborne", int'(airborne), 0);

        // low ceiling: y reaches 0 before the full height
        load(50, 10); snap();
        press_jump();
        ticks(10);
        chk("ceil_y", int'(y_pos), 0);
        chk("ceil_ups", yup - s_yup, 10);
        chk("ceil_rise", int'(state), 1);
        tick();
        chk("ceil_hang", int'(state), 2);

        // reset mid-rise
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        load(50, 115);
        press_jump();
        ticks(3);
        chk("midrise_state", int'(state), 1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_outs", int'({x_enable, x_updown, y_enable, y_updown, airborne}), 0);
        load(50, 115); snap();
        tick();
        chk("rst_no_y", yup + ydn - s_yup - s_ydn, 0);
        chk("rst_ground", int'(state), 0);

        // walk off a ledge, press jump while falling
        load(50, 100);
        tick();
        chk("ledge_fall", int'(state), 3);
        press_jump();
        ticks(16);
        chk("ledge_land", int'(state), 0);
        chk("ledge_y", int'(y_pos), 115);
        snap();
        ticks(3);
        chk("no_queued_jump", int'(state), 0);
        chk("no_queued_y", yup + ydn - s_yup - s_ydn, 0);

        // jump held: exactly one jump
        @(negedge clk) key_jump = 1'b1;
        @(negedge clk);
        snap();
        tick();
        chk("held_rise", int'(state), 1);
        ticks(52);
        chk("held_land", int'(state), 0);
        chk("held_y", int'(y_pos), 115);
        chk("held_ups", yup - s_yup, 24);
        snap();
        ticks(4);
        chk("held_once", yup + ydn - s_yup - s_ydn, 0);
        key_jump = 1'b0;

        chk("pulse_width", wide, 0);
        chk("airborne_track", airb_bad, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mario_motion_ctrl.md
# mario_motion_ctrl

Frame-rate motion controller for the player sprite. It sits directly upstream of the x and y position counters. Once per frame tick it converts player keys and the current position into one-cycle `enable`/`updown` pulses for each counter. A GROUND/RISE/HANG/FALL state machine drives the jump arc and bounds both axes.

## Interface

Parameters:
- `JUMP_HEIGHT`, default 24 — number of up-steps, one pixel each, in a full rise.
- `HANG_FRAMES`, default 3 — frame ticks spent at the apex with no vertical motion.
- `GROUND_Y`, default 115 — y value of standing height (y grows downward).
- `X_MAX`, default 155 — right-hand x limit.

Ports:
- `clk`  in  1  — system clock; the only clock in the block. One clock; reset is synchronous and active-high.
- `reset`  in  1  — synchronous, active-high reset.
- `frame_tick`  in  1  — single-cycle pulse, once per frame.
- `key_left`  in  1  — level; player holds left.
- `key_right`  in  1  — level; player holds right.
- `key_jump`  in  1  — level; a rising edge requests a jump.
- `x_pos`  in  8  — current x counter value.
- `y_pos`  in  8  — current y counter value.
- `x_enable`  out  1  — one-cycle step pulse to the x counter.
- `x_updown`  out  1  — 1 = increment (right), 0 = decrement.
- `y_enable`  out  1  — one-cycle step pulse to the y counter.
- `y_updown`  out  1  — 1 = increment (down), 0 = decrement (up).
- `state`  out  2  — 0 GROUND, 1 RISE, 2 HANG, 3 FALL.
- `airborne`  out  1  — high whenever `state` is not GROUND.

## Operation

- Reset values:
  - state = GROUND
  - all outputs 0
  - rise_cnt = 0, hang_cnt = 0
  - jump_req = 0, jump_prev = 0
- Jump capture:
  - `jump_prev` registers `key_jump` every cycle.
  - `jump_req` sets on `key_jump & ~jump_prev` only while state = GROUND.
  - Presses while airborne are discarded, not queued.
  - `jump_req` clears when consumed.
- Horizontal motion, evaluated on `frame_tick` in every state:
  - right only and `x_pos < X_MAX` → x step with updown = 1.
  - left only and `x_pos > 0` → x step with updown = 0.
  - both keys, neither key, or at the limit → no x step.
- State transitions, evaluated only on a cycle with `frame_tick` = 1:
  - GROUND, `jump_req` = 1: go to RISE, clear `jump_req`, rise_cnt = 1, issue an up-step (first step on the same tick).
  - GROUND, otherwise: if `y_pos < GROUND_Y`, go to FALL (walked off a ledge); else stay, no y step.
  - RISE, `y_pos == 0`: go to HANG, hang_cnt = 0, no y step.
  - RISE, `rise_cnt == JUMP_HEIGHT`: go to HANG, hang_cnt = 0, no y step.
  - RISE, otherwise: up-step, rise_cnt + 1.
  - HANG, `hang_cnt == HANG_FRAMES-1`: go to FALL, no y step.
  - HANG, otherwise: hang_cnt + 1, no y step.
  - FALL, `y_pos >= GROUND_Y`: go to GROUND, no y step.
  - FALL, otherwise: down-step (y_updown = 1).
- Counter widths:
  - rise_cnt is 6 bits and saturates; it never wraps.
  - hang_cnt is 4 bits.
  - Position comparisons are unsigned 8-bit.
- Reset asserted mid-jump returns the block to GROUND with no pulses. The downstream counters are reset by the same system event.

## Timing

- `frame_tick` sampled high at edge T:
  - `x_enable`/`y_enable` (with matching `updown`) are high for exactly the cycle after T, then low.
  - `state` and `airborne` update at edge T.
- The counters consume the pulse at edge T+1, so the new position is visible from T+2.
- `frame_tick` pulses must be at least 3 cycles apart. Behaviour with closer spacing is undefined.
- `updown` outputs are only meaningful while the matching `enable` is high. They hold their last value otherwise.
- With no `frame_tick`, all pulses stay low and state holds.
- Jump latency: press → RISE at the first `frame_tick` at least 2 cycles after the `key_jump` rising edge.

## Test plan

- Reset, y_pos = 115, right held, 5 ticks → 5 x pulses with x_updown = 1, each exactly 1 cycle wide; y_enable never high; state = 0.
- x_pos = 155, right held, 3 ticks → no x_enable. x_pos = 0, left held → no x_enable. Both keys held → no x_enable.
- Jump from y = 115 with a counter model attached → 24 up-steps, y = 91, 3 hang ticks with no y pulse, 24 down-steps, then state = GROUND at y = 115. airborne is high throughout the jump.
- Jump with y_pos starting at 10 → RISE stops at y = 0 after 10 up-steps and enters HANG early.
- Jump pressed during FALL, then released → no jump after landing. Jump held continuously → exactly one jump (edge-detected).
- Reset pulsed for 1 cycle mid-RISE → next cycle state = 0, all outputs 0; the next tick with y_pos = 115 gives no y pulse.
